// File: rtl/odd_even_burst_sched_pkg.sv
// Shared types and constants for the odd/even burst scheduler and its counter core.
package odd_even_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int EVEN_START = 0;
   localparam int ODD_START  = 1;
   localparam int STEP       = 2;

endpackage

// File: rtl/odd_even_burst_sched_if.sv
// Requester-side bus of the burst scheduler: requests in, grant/stream/completion out.
interface odd_even_burst_sched_if #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 4,
   parameter int LW    = 4
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_mode;
   logic [NREQ*LW-1:0] req_len;
   logic [NREQ-1:0]    gnt;
   logic               busy;
   logic [WIDTH-1:0]   Q;
   logic               q_valid;
   logic [NREQ-1:0]    done;

   modport master (
      output req, req_mode, req_len,
      input  gnt, busy, Q, q_valid, done
   );

   modport slave (
      input  req, req_mode, req_len,
      output gnt, busy, Q, q_valid, done
   );
endinterface

// File: rtl/odd_even_burst_sched_counter_core.sv
// Odd/even counter: loads 0 or 1 by parity, then steps by two with natural wrap.
module odd_even_counter_core
   import odd_even_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             load,
   input  logic             step,
   input  logic             mode,
   output logic [WIDTH-1:0] Q
);

   always_ff @(posedge Clock) begin
      if (!Clear)
         Q <= '0;
      else if (load)
         Q <= mode ? WIDTH'(ODD_START) : WIDTH'(EVEN_START);
      else if (step)
         Q <= Q + WIDTH'(STEP);
   end

endmodule

// File: rtl/odd_even_burst_sched.sv
// Round-robin scheduler sharing one odd/even counter among NREQ burst requesters.
module odd_even_burst_sched
   import odd_even_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int WIDTH = 4,
   parameter int LW    = 4
) (
   input  logic                   Clock,
   input  logic                   Clear,
   odd_even_burst_sched_if.slave  bus
);

   localparam int IDW = $clog2(NREQ);

   state_t            state;
   logic [IDW-1:0]    ptr;
   logic [IDW-1:0]    id;
   logic              mode_l;
   logic [LW-1:0]     len_l;
   logic [LW-1:0]     rem;
   logic [IDW-1:0]    pick;
   logic              pick_mode;
   logic [LW-1:0]     pick_len;
   logic [NREQ-1:0]   id_onehot;
   logic              cnt_load;
   logic              cnt_step;

   // Descending scan so the requester closest to ptr (upward, wrapping) wins last.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDW-1:0]  p);
      logic [IDW-1:0] win;
      logic [IDW-1:0] kk;
      int             k;
      win = p;
      for (int i = NREQ - 1; i >= 0; i--) begin
         k  = (int'(p) + i) % NREQ;
         kk = IDW'(k);
         if (r[kk])
            win = kk;
      end
      return win;
   endfunction

   assign pick = rr_pick(bus.req, ptr);

   always_comb begin
      pick_mode = 1'b0;
      pick_len  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == pick) begin
            pick_mode = bus.req_mode[i];
            pick_len  = bus.req_len[i*LW +: LW];
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Clear) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|bus.req) begin
                  id     <= pick;
                  mode_l <= pick_mode;
                  len_l  <= pick_len;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               rem   <= len_l;
               state <= (len_l == '0) ? DONE : RUN;
            end
            RUN: begin
               rem <= rem - LW'(1);
               if (rem == LW'(1))
                  state <= DONE;
            end
            DONE: begin
               ptr   <= (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The last element stays on Q through DONE and IDLE, so no step on it.
   assign cnt_load = (state == LOAD);
   assign cnt_step = (state == RUN) && (rem != LW'(1));

   odd_even_counter_core #(.WIDTH(WIDTH)) u_core (
      .Clock (Clock),
      .Clear (Clear),
      .load  (cnt_load),
      .step  (cnt_step),
      .mode  (mode_l),
      .Q     (bus.Q)
   );

   assign id_onehot   = NREQ'(1) << id;
   assign bus.busy    = (state != IDLE);
   assign bus.q_valid = (state == RUN);
   assign bus.gnt     = bus.busy ? id_onehot : '0;
   assign bus.done    = (state == DONE) ? id_onehot : '0;

endmodule

// File: tb/tb_odd_even_burst_sched.sv
// Bench for odd_even_burst_sched: directed scenarios plus random traffic against a burst-level model.
module tb_odd_even_burst_sched;

   localparam int NREQ  = 2;
   localparam int WIDTH = 4;
   localparam int LW    = 4;

   logic Clock = 1'b0;
   logic Clear;

   always #5 Clock = ~Clock;

   odd_even_burst_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .LW(LW)) bus ();

   odd_even_burst_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LW(LW)) dut (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (bus)
   );

   typedef struct {
      logic [NREQ-1:0]  gnt;
      logic             qv;
      logic [WIDTH-1:0] q;
      logic [NREQ-1:0]  done;
   } exp_t;

   exp_t             expq[$];
   int               ptr_m;
   logic [WIDTH-1:0] lastq_m;
   int               checks   = 0;
   int               failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // A granted burst expands into its full cycle-by-cycle picture: LOAD, L values, DONE.
   task automatic model_edge();
      exp_t e;
      int   rq, id, len, start, idx;
      if (!Clear) begin
         expq.delete();
         ptr_m   = 0;
         lastq_m = '0;
      end else if (expq.size() != 0) begin
         void'(expq.pop_front());
      end else begin
         rq = int'(bus.req);
         if (rq != 0) begin
            id = -1;
            for (int k = 0; k < NREQ; k++) begin
               idx = (ptr_m + k) % NREQ;
               if (id < 0 && ((rq >> idx) & 1) == 1) id = idx;
            end
            len   = (int'(bus.req_len) >> (id * LW)) & ((1 << LW) - 1);
            start = (int'(bus.req_mode) >> id) & 1;
            e.gnt  = NREQ'(1 << id);
            e.done = '0;
            e.qv   = 1'b0;
            e.q    = lastq_m;
            expq.push_back(e);
            for (int j = 0; j < len; j++) begin
               e.qv = 1'b1;
               e.q  = WIDTH'((start + 2 * j) % (1 << WIDTH));
               expq.push_back(e);
            end
            e.qv   = 1'b0;
            e.q    = (len > 0) ? WIDTH'((start + 2 * (len - 1)) % (1 << WIDTH)) : WIDTH'(start);
            e.done = e.gnt;
            expq.push_back(e);
            lastq_m = e.q;
            ptr_m   = (id + 1) % NREQ;
         end
      end
   endtask

   task automatic compare();
      exp_t e;
      logic busy_e;
      if (expq.size() != 0) begin
         e      = expq[0];
         busy_e = 1'b1;
      end else begin
         e.gnt  = '0;
         e.qv   = 1'b0;
         e.q    = lastq_m;
         e.done = '0;
         busy_e = 1'b0;
      end
      chk("gnt",     bus.gnt,     e.gnt);
      chk("busy",    bus.busy,    busy_e);
      chk("q_valid", bus.q_valid, e.qv);
      chk("Q",       bus.Q,       e.q);
      chk("done",    bus.done,    e.done);
   endtask

   task automatic tick();
      @(posedge Clock);
      model_edge();
      #1;
      compare();
   endtask

   initial begin
      Clear        = 1'b0;
      bus.req      = 2'b11;
      bus.req_mode = 2'b00;
      bus.req_len  = 8'h44;
      ptr_m        = 0;
      lastq_m      = '0;

      // Reset held with both requests up
      repeat (3) tick();

      // Requester 0, even, length 4
      Clear        = 1'b1;
      bus.req      = 2'b01;
      bus.req_mode = 2'b00;
      bus.req_len  = 8'h04;
      tick();
      bus.req = 2'b00;
      repeat (8) tick();

      // Requester 1, odd, length 9 with wrap
      bus.req      = 2'b10;
      bus.req_mode = 2'b10;
      bus.req_len  = 8'h90;
      tick();
      bus.req = 2'b00;
      repeat (12) tick();

      // Both held high from reset, length 2 each
      Clear        = 1'b0;
      bus.req      = 2'b11;
      bus.req_mode = 2'b10;
      bus.req_len  = 8'h22;
      repeat (2) tick();
      Clear = 1'b1;
      repeat (15) tick();
      bus.req = 2'b00;
      repeat (6) tick();

      // Zero-length burst
      bus.req      = 2'b01;
      bus.req_mode = 2'b00;
      bus.req_len  = 8'h00;
      tick();
      bus.req = 2'b00;
      repeat (4) tick();

      // Reset mid-burst while Q shows 6
      bus.req      = 2'b01;
      bus.req_mode = 2'b00;
      bus.req_len  = 8'h08;
      tick();
      bus.req = 2'b00;
      repeat (4) tick();
      chk("mid_q6", bus.Q, 6);
      Clear   = 1'b0;
      bus.req = 2'b11;
      tick();
      chk("rst_q0", bus.Q, 0);
      Clear = 1'b1;
      tick();
      chk("rst_gnt0_first", bus.gnt, 2'b01);
      bus.req = 2'b00;
      repeat (12) tick();

      // Random traffic, occasional resets and mid-burst input churn
      repeat (3000) begin
         Clear        = ($urandom_range(0, 79) != 0);
         bus.req      = ($urandom_range(0, 2) == 0) ? 2'b00 : NREQ'($urandom_range(0, 3));
         bus.req_mode = NREQ'($urandom_range(0, 3));
         bus.req_len  = {LW'($urandom_range(0, 11)), LW'($urandom_range(0, 11))};
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
